// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: sequences START, 8 data bits, ACK and STOP on open-drain
// scl/sda using quarter-bit timing, with slave clock-stretch support.
module i2c_byte_engine #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_write,
    input  logic             cmd_read,
    input  logic             cmd_ack,
    input  logic [7:0]       tx_data,
    output logic [7:0]       rx_data,
    output logic             ack_in,
    output logic             done,
    output logic             busy,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       q_reg, q_next;
    logic [2:0]       bit_reg, bit_next;
    logic [DIV_W-1:0] cnt_reg;
    logic             done_reg, done_next;
    logic             scl_oe_reg, scl_oe_next;
    logic             sda_oe_reg, sda_oe_next;
    logic [7:0]       rx_reg;
    logic             ack_in_reg;

    // Command fields captured at acceptance
    logic             write_reg;
    logic             data_reg;
    logic             stop_reg;
    logic             ack_reg;
    logic [7:0]       tx_reg;

    logic accept;
    logic tick;
    logic stretch;
    logic advance;
    logic phase_end;

    // Fields as seen by the output decode: the acceptance cycle already needs them
    logic       f_write;
    logic       f_ack;
    logic [7:0] f_tx;

    assign cmd_ready = (state_reg == ST_IDLE) && !done_reg;
    assign busy      = (state_reg != ST_IDLE) || done_reg;
    assign accept    = cmd_valid && cmd_ready;

    // >= keeps a lowered clk_div from letting the counter run past it
    assign tick      = (cnt_reg >= clk_div);
    assign stretch   = (q_reg == 2'd1) && !scl_in;
    assign advance   = (state_reg != ST_IDLE) && tick && !stretch;
    assign phase_end = advance && (q_reg == 2'd3);

    assign f_write = accept ? cmd_write : write_reg;
    assign f_ack   = accept ? cmd_ack   : ack_reg;
    assign f_tx    = accept ? tx_data   : tx_reg;

    assign done    = done_reg;
    assign scl_oe  = scl_oe_reg;
    assign sda_oe  = sda_oe_reg;
    assign rx_data = rx_reg;
    assign ack_in  = ack_in_reg;

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            q_reg      <= 2'd0;
            bit_reg    <= 3'd0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            scl_oe_reg <= 1'b0;
            sda_oe_reg <= 1'b0;
            rx_reg     <= 8'h00;
            ack_in_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            bit_reg    <= bit_next;
            done_reg   <= done_next;
            scl_oe_reg <= scl_oe_next;
            sda_oe_reg <= sda_oe_next;

            if (accept || (state_reg == ST_IDLE)) begin
                cnt_reg <= '0;
            end else if (tick) begin
                cnt_reg <= stretch ? cnt_reg : '0;
            end else begin
                cnt_reg <= cnt_reg + DIV_W'(1);
            end

            // sda is sampled on the tick that closes q2 (scl high)
            if (advance && (q_reg == 2'd2)) begin
                if ((state_reg == ST_DATA) && !write_reg) begin
                    rx_reg <= {rx_reg[6:0], sda_in};
                end
                if ((state_reg == ST_ACK) && write_reg) begin
                    ack_in_reg <= sda_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg <= 1'b0;
            data_reg  <= 1'b0;
            stop_reg  <= 1'b0;
            ack_reg   <= 1'b0;
            tx_reg    <= 8'h00;
        end else if (accept) begin
            write_reg <= cmd_write;
            data_reg  <= cmd_write || cmd_read;
            stop_reg  <= cmd_stop;
            ack_reg   <= cmd_ack;
            tx_reg    <= tx_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        bit_next   = bit_reg;

        if (advance) begin
            q_next = q_reg + 2'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    q_next   = 2'd0;
                    bit_next = 3'd7;
                    if (cmd_start) begin
                        state_next = ST_START;
                    end else if (cmd_write || cmd_read) begin
                        state_next = ST_DATA;
                    end else if (cmd_stop) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                if (phase_end) begin
                    if (data_reg) begin
                        state_next = ST_DATA;
                    end else if (stop_reg) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (phase_end) begin
                    if (bit_reg == 3'd0) begin
                        state_next = ST_ACK;
                    end else begin
                        bit_next = bit_reg - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (phase_end) begin
                    state_next = stop_reg ? ST_STOP : ST_IDLE;
                end
            end
            ST_STOP: begin
                if (phase_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the phase being entered, so the registered lines
    // change exactly at the phase boundary.
    always_comb begin
        scl_oe_next = scl_oe_reg;
        sda_oe_next = sda_oe_reg;
        done_next   = (state_next == ST_IDLE) && ((state_reg != ST_IDLE) || accept);

        case (state_next)
            ST_START: begin
                case (q_next)
                    2'd0: sda_oe_next = 1'b0;
                    2'd1: begin sda_oe_next = 1'b0; scl_oe_next = 1'b0; end
                    2'd2: begin sda_oe_next = 1'b1; scl_oe_next = 1'b0; end
                    default: begin sda_oe_next = 1'b1; scl_oe_next = 1'b1; end
                endcase
            end
            ST_DATA: begin
                scl_oe_next = (q_next == 2'd0) || (q_next == 2'd3);
                sda_oe_next = f_write ? ~f_tx[bit_next] : 1'b0;
            end
            ST_ACK: begin
                scl_oe_next = (q_next == 2'd0) || (q_next == 2'd3);
                sda_oe_next = f_write ? 1'b0 : ~f_ack;
            end
            ST_STOP: begin
                case (q_next)
                    2'd0: begin sda_oe_next = 1'b1; scl_oe_next = 1'b1; end
                    2'd1: begin sda_oe_next = 1'b1; scl_oe_next = 1'b0; end
                    default: begin sda_oe_next = 1'b0; scl_oe_next = 1'b0; end
                endcase
            end
            default: begin
                scl_oe_next = scl_oe_reg;
                sda_oe_next = sda_oe_reg;
            end
        endcase
    end

endmodule

// File: doc/i2c_byte_engine.md
I2C_BYTE_ENGINE -- requirements
Module: i2c_byte_engine

Interface
REQ-001 Parameter DIV_W, default 16: width of the clk_div input.
REQ-002 clk  input  1  single clock; all logic rises on its positive edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_div  input  DIV_W  quarter-bit divisor; one quarter-bit lasts clk_div+1 clk cycles.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  engine can accept a command (high only in IDLE).
REQ-007 cmd_start  input  1  issue START (or repeated START) before the data phase.
REQ-008 cmd_stop  input  1  issue STOP after the data phase.
REQ-009 cmd_write  input  1  transmit tx_data MSB-first, then sample ACK.
REQ-010 cmd_read  input  1  receive 8 bits MSB-first, then drive cmd_ack.
REQ-011 cmd_ack  input  1  ACK bit level to drive on read (0 = ACK, 1 = NACK).
REQ-012 tx_data  input  8  byte to transmit.
REQ-013 rx_data  output  8  last received byte.
REQ-014 ack_in  output  1  ACK level sampled on the last write (1 = NACK).
REQ-015 done  output  1  one-cycle pulse when a command completes.
REQ-016 busy  output  1  high from command acceptance to done.
REQ-017 scl_oe / sda_oe  output  1 each  pull line low when 1; release when 0.
REQ-018 scl_in / sda_in  input  1 each  sensed bus levels.

Function
REQ-019 Handshake: a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1; all cmd_* inputs and tx_data are latched in that cycle.
REQ-020 cmd_write=1 with cmd_read=1 is treated as a write; with both 0, only the START and/or STOP phases run.
REQ-021 Tick counter: cleared on acceptance; counts 0..clk_div; tick when count==clk_div; clk_div=0 gives a tick every cycle.
REQ-022 States: IDLE, START, DATA (8 bits), ACK (1 bit), STOP, in that order. Phases that are not requested are skipped.
REQ-023 Each non-IDLE bit has 4 quarter phases q0..q3; the phase advances on a tick.
REQ-024 START: q0 release sda (scl unchanged); q1 release scl; q2 sda low; q3 scl low.
REQ-025 DATA/ACK: q0 set sda (scl low); q1 release scl; q2 scl high, sda_in sampled at the end of q2; q3 scl low.
REQ-026 Write sda source: tx_data bit 7 down to 0, then release for ACK; sample at ACK q2 goes to ack_in.
REQ-027 Read sda source: released for 8 bits, sampled bits shift into rx_data MSB-first; then cmd_ack drives the ACK bit (drive low if 0).
REQ-028 STOP: q0 sda low, scl low; q1 release scl; q2 release sda; q3 hold both released.
REQ-029 Clock stretching: in q1, the end-of-q1 tick is ignored while scl_in=0; the tick counter holds at clk_div until scl_in=1.
REQ-030 Latency without stretching: done asserts exactly Q*(clk_div+1) cycles after the acceptance cycle.
  - Q = 4 for START + 36 for data+ACK + 4 for STOP, counting only the phases run.
REQ-031 done and busy fall and cmd_ready rises in the same cycle; a new command can be accepted in the cycle after done.
REQ-032 After a command without STOP, IDLE keeps scl_oe=1 (bus held), and sda_oe keeps the value from the last phase.
REQ-033 cmd_valid while busy is ignored, and latched fields do not change mid-command.
REQ-034 Changing clk_div mid-command takes effect at the next counter compare.

Reset
REQ-035 On reset=1 at a clock edge:
  - state = IDLE; counter = 0.
  - scl_oe = 0, sda_oe = 0, busy = 0, done = 0, cmd_ready = 1, rx_data = 0x00, ack_in = 0.
REQ-036 Reset asserted mid-command aborts immediately; both lines are released on the next edge, and no done is issued.

Verification
REQ-037 clk_div=1, write 0xA5 with start+stop, sda_in follows sda_oe except ACK sampled low:
  - done exactly 88 cycles after acceptance; sda sequence 1,0,1,0,0,1,0,1; ack_in = 0.
REQ-038 clk_div=0, read with start, cmd_ack=1, slave bits 0x3C:
  - rx_data = 0x3C; sda_oe = 0 during ACK; done after 40 cycles; scl_oe = 1 held in IDLE.
REQ-039 Repeated start: write without stop, then start+read+stop:
  - second START q0 releases sda while scl is low; no STOP appears between the two commands.
REQ-040 Clock stretch: clk_div=3; slave holds scl_in=0 for 20 extra cycles on bit 3 -> done is delayed by exactly 20 cycles.
REQ-041 Reset in the middle of bit 5 -> next edge: scl_oe = 0, sda_oe = 0, busy = 0, cmd_ready = 1, no done pulse.
REQ-042 Write with a NACKing slave (sda_in=1 at ACK) -> ack_in = 1; cmd_valid pulses while busy are not accepted.
